// File: rtl/mem_if_pkg.sv
// Shared definitions for the MEM-stage data-memory request/response interface:
// access codes, width flags and the responder FSM state encoding.
package mem_if_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] MEM_RSVD  = 2'b11;

    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for the data RAM: merges a store into the old word and
// extracts load data, little-endian (lane 0 = bits [7:0]).
module byte_lane_unit
    import mem_if_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic        word_byte,
    output logic [31:0] merged_word,
    output logic [31:0] read_data
);

    always_comb begin
        // NOTE: every output gets a default first so no path through this block can infer a latch.
        merged_word = wdata;
        read_data   = old_word;
        if (word_byte == ACC_BYTE) begin
            merged_word               = old_word;
            merged_word[8*lane +: 8]  = wdata[7:0];
            read_data                 = {24'd0, old_word[8*lane +: 8]};
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: owns the data RAM, services one request at a time with
// a fixed latency and returns data/acknowledge over a valid/ready channel.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_mem_write_read,
    input  logic        req_word_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    resp_state_t state, next_state;
    logic [3:0]  cnt, next_cnt;

    logic [1:0]  cap_code;
    logic        cap_wb;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, resp_done, resp_entry;
    logic [1:0]  eff_code;
    logic        eff_wb;
    logic [31:0] eff_addr, eff_wdata;
    logic [29:0] word_index;
    logic [IDX_W-1:0] ram_idx;
    logic        out_of_range, misaligned, bad_code, acc_err, ram_we;
    logic [31:0] old_word, merged_word, read_data;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign resp_done  = resp_valid && resp_ready;

    // With LATENCY==1 the access happens on the acceptance edge, so it must see the live request.
    assign eff_code  = (state == IDLE) ? req_mem_write_read : cap_code;
    assign eff_wb    = (state == IDLE) ? req_word_byte      : cap_wb;
    assign eff_addr  = (state == IDLE) ? req_addr           : cap_addr;
    assign eff_wdata = (state == IDLE) ? req_wdata          : cap_wdata;

    assign word_index   = eff_addr[31:2];
    assign ram_idx      = eff_addr[IDX_W+1:2];
    assign out_of_range = (word_index >= 30'(DEPTH_WORDS));
    assign misaligned   = (eff_wb == ACC_WORD) && (eff_addr[1:0] != 2'b00);
    assign bad_code     = (eff_code != MEM_READ) && (eff_code != MEM_WRITE);
    assign acc_err      = out_of_range || misaligned || bad_code;

    assign old_word = mem[ram_idx];
    assign ram_we   = resp_entry && !rst && !acc_err && (eff_code == MEM_WRITE);

    byte_lane_unit u_lane (
        .old_word    (old_word),
        .lane        (eff_addr[1:0]),
        .wdata       (eff_wdata),
        .word_byte   (eff_wb),
        .merged_word (merged_word),
        .read_data   (read_data)
    );

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        resp_entry = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        next_state = RESP;
                        resp_entry = 1'b1;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                    resp_entry = 1'b1;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_code  <= req_mem_write_read;
            cap_wb    <= req_word_byte;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (resp_entry) begin
            resp_err   <= acc_err;
            resp_rdata <= (!acc_err && eff_code == MEM_READ) ? read_data : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: RAM contents are deliberately not reset; rst only gates the write enable.
        if (ram_we) mem[ram_idx] <= merged_word;
    end

endmodule
